// File: rtl/brick_store_arbiter.sv
// 64 x 2-bit brick hardness store with one access per cycle shared by render, physics and a level loader.
// Optional BRICK_ARB_STARVE_EN: starvation counter that forces physics through after STARVE_LIMIT denials.
module brick_store_arbiter #(
    parameter int unsigned STARVE_LIMIT  = 8,
    parameter bit          LOAD_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_req,
    input  logic [2:0] level,
    output logic       load_busy,
    input  logic       r_req,
    input  logic [5:0] r_addr,
    output logic [1:0] r_data,
    output logic       r_valid,
    input  logic       p_req,
    input  logic [5:0] p_addr,
    input  logic       p_op,
    output logic       p_gnt,
    output logic [1:0] p_data,
    output logic       p_done,
    output logic [6:0] brick_count,
    output logic       cleared
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WR_PEND = 2'd2, DONE = 2'd3} state_t;

    function automatic logic [1:0] level_value(input logic [5:0] addr, input logic [2:0] lvl);
        logic [4:0] sum;
        sum = {2'b00, addr[5:3]} + {2'b00, addr[2:0]} + {2'b00, lvl};
        if (addr[5:3] <= lvl) begin
            level_value = 2'(sum % 5'd3) + 2'd1;
        end else begin
            level_value = 2'd0;
        end
    endfunction

    state_t     state_r, state_s;
    logic [1:0] mem_r [64];
    logic [5:0] load_addr_r;
    logic [2:0] load_level_r, pend_level_r, pend_level_s, start_level_s;
    logic       pend_r, pend_s, loaded_r, loaded_s, cleared_r, cleared_s;
    logic [5:0] p_addr_r;
    logic [1:0] p_val_r, rd_val_s, load_val_s, r_data_r;
    logic [6:0] count_r, count_s;
    logic       r_valid_r, load_start_s, p_gnt_s, p_wr_s, r_win_s, phys_win_s, starve_hit_s;

`ifdef BRICK_ARB_STARVE_EN
    localparam logic [7:0] STARVE_W = 8'(STARVE_LIMIT);
    logic [7:0] starve_r, starve_s;

    assign starve_hit_s = (starve_r == STARVE_W);

    // Count cycles physics wants the port but loses it to render.
    always_comb begin
        starve_s = starve_r;
        if (p_gnt_s || p_wr_s) begin
            starve_s = 8'd0;
        end else if (p_req && r_req && (((state_r == IDLE) && !load_start_s) || (state_r == WR_PEND))) begin
            starve_s = starve_r + 8'd1;
        end else begin
            starve_s = starve_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_r <= 8'd0;
        end else begin
            starve_r <= starve_s;
        end
    end
`else
    assign starve_hit_s = 1'b0;
`endif

    // Next-state, arbitration and bookkeeping.
    always_comb begin
        state_s       = state_r;
        count_s       = count_r;
        loaded_s      = loaded_r;
        pend_s        = pend_r;
        pend_level_s  = pend_level_r;
        load_start_s  = 1'b0;
        p_gnt_s       = 1'b0;
        p_wr_s        = 1'b0;
        r_win_s       = 1'b0;
        phys_win_s    = p_req && (!r_req || starve_hit_s);
        rd_val_s      = mem_r[p_addr];
        load_val_s    = level_value(load_addr_r, load_level_r);
        start_level_s = pend_r ? pend_level_r : level;
        case (state_r)
            IDLE: begin
                load_start_s = pend_r || load_req;
                if (load_start_s) begin
                    state_s = LOAD;
                    count_s = 7'd0;
                    pend_s  = 1'b0;
                end else if (phys_win_s) begin
                    p_gnt_s = 1'b1;
                    if (p_op && (rd_val_s != 2'd0)) begin
                        state_s = WR_PEND;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
                r_win_s = r_req && !p_gnt_s;
            end
            LOAD: begin
                if (load_val_s != 2'd0) begin
                    count_s = count_r + 7'd1;
                end else begin
                    count_s = count_r;
                end
                if (load_addr_r == 6'd63) begin
                    state_s  = IDLE;
                    loaded_s = 1'b1;
                end else begin
                    state_s = LOAD;
                end
            end
            WR_PEND: begin
                if (load_req) begin
                    pend_s       = 1'b1;
                    pend_level_s = level;
                end else begin
                    pend_s = pend_r;
                end
                if (phys_win_s) begin
                    p_wr_s  = 1'b1;
                    state_s = DONE;
                    if (p_val_r == 2'd1) begin
                        count_s = count_r - 7'd1;
                    end else begin
                        count_s = count_r;
                    end
                end else begin
                    state_s = WR_PEND;
                end
                r_win_s = r_req && !p_wr_s;
            end
            DONE: begin
                if (load_req) begin
                    pend_s       = 1'b1;
                    pend_level_s = level;
                end else begin
                    pend_s = pend_r;
                end
                state_s = IDLE;
                r_win_s = r_req;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        cleared_s = loaded_s && (count_s == 7'd0) && (state_s != LOAD);
    end

    // Control and output registers; a pending load at reset release starts the level-0 fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            load_addr_r  <= 6'd0;
            load_level_r <= 3'd0;
            pend_r       <= LOAD_ON_RESET;
            pend_level_r <= 3'd0;
            loaded_r     <= 1'b0;
            cleared_r    <= 1'b0;
            count_r      <= 7'd0;
            p_addr_r     <= 6'd0;
            p_val_r      <= 2'd0;
            r_data_r     <= 2'd0;
            r_valid_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            pend_r       <= pend_s;
            pend_level_r <= pend_level_s;
            loaded_r     <= loaded_s;
            cleared_r    <= cleared_s;
            count_r      <= count_s;
            r_valid_r    <= r_win_s;
            if (load_start_s) begin
                load_addr_r  <= 6'd0;
                load_level_r <= start_level_s;
            end else if (state_r == LOAD) begin
                load_addr_r <= load_addr_r + 6'd1;
            end
            if (p_gnt_s) begin
                p_addr_r <= p_addr;
                p_val_r  <= rd_val_s;
            end
            if (r_win_s) begin
                r_data_r <= mem_r[r_addr];
            end
        end
    end

    // Store array: loader writes during LOAD, physics writes back the decremented hit value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                mem_r[i] <= 2'd0;
            end
        end else if (state_r == LOAD) begin
            mem_r[load_addr_r] <= load_val_s;
        end else if (p_wr_s) begin
            mem_r[p_addr_r] <= p_val_r - 2'd1;
        end
    end

    assign load_busy   = (state_r == LOAD);
    assign p_done      = (state_r == DONE);
    assign p_gnt       = p_gnt_s;
    assign p_data      = p_val_r;
    assign r_data      = r_data_r;
    assign r_valid     = r_valid_r;
    assign brick_count = count_r;
    assign cleared     = cleared_r;

endmodule

// File: tb/tb_brick_store_arbiter.sv
// Scoreboard bench for brick_store_arbiter: render and physics results are queued at drive time
// and compared when r_valid / p_done appear.
module tb_brick_store_arbiter;

    logic       clk = 1'b0;
    logic       rst, load_req, r_req, r_valid, p_req, p_op, p_gnt, p_done, load_busy, cleared;
    logic [2:0] level;
    logic [5:0] r_addr, p_addr;
    logic [1:0] r_data, p_data;
    logic [6:0] brick_count;

    int checks = 0;
    int failures = 0;
    logic [1:0] model [64];
    logic [1:0] rq [$];
    logic [1:0] pq [$];

    always #5 clk = ~clk;

    brick_store_arbiter #(.STARVE_LIMIT(8), .LOAD_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .level(level), .load_busy(load_busy),
        .r_req(r_req), .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid),
        .p_req(p_req), .p_addr(p_addr), .p_op(p_op), .p_gnt(p_gnt), .p_data(p_data),
        .p_done(p_done), .brick_count(brick_count), .cleared(cleared)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] pattern(input int a, input int l);
        int row, col;
        row = a / 8;
        col = a % 8;
        return (row <= l) ? 2'(((row + col + l) % 3) + 1) : 2'd0;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 64; i++) if (model[i] != 2'd0) n++;
        return n;
    endfunction

    task automatic set_model(input int l);
        for (int i = 0; i < 64; i++) model[i] = pattern(i, l);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: pops expectations whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (r_valid === 1'b1) begin
                if (rq.size() > 0) check_eq("r_data", r_data, rq.pop_front());
                else check_eq("r_valid_unexp", r_valid, 0);
            end
            if (p_done === 1'b1) begin
                if (pq.size() > 0) check_eq("p_data", p_data, pq.pop_front());
                else check_eq("p_done_unexp", p_done, 0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_load_busy"}, load_busy, 0);
        check_eq({tag, "_r_valid"}, r_valid, 0);
        check_eq({tag, "_r_data"}, r_data, 0);
        check_eq({tag, "_p_gnt"}, p_gnt, 0);
        check_eq({tag, "_p_done"}, p_done, 0);
        check_eq({tag, "_p_data"}, p_data, 0);
        check_eq({tag, "_count"}, brick_count, 0);
        check_eq({tag, "_cleared"}, cleared, 0);
    endtask

    task automatic wait_load();
        int  n = 0;
        bit  seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (load_busy === 1'b1) begin
                n++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        check_eq("load_cycles", n, 64);
        tick();
    endtask

    task automatic render_read(input logic [5:0] a);
        r_req  = 1'b1;
        r_addr = a;
        rq.push_back(model[a]);
        tick();
        r_req = 1'b0;
    endtask

    task automatic phys_start(input logic [5:0] a, input logic op);
        pq.push_back(model[a]);
        p_req  = 1'b1;
        p_addr = a;
        p_op   = op;
    endtask

    task automatic phys_finish(input logic [5:0] a, input logic op);
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (p_done === 1'b1) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check_eq("p_done_seen", done, 1);
        p_req = 1'b0;
        if (op && model[a] != 2'd0) model[a] = model[a] - 2'd1;
        if (done) begin
            check_eq("count_after_op", brick_count, model_count());
            check_eq("cleared_after_op", cleared, model_count() == 0);
        end
        tick();
    endtask

    task automatic phys_op(input logic [5:0] a, input logic op);
        phys_start(a, op);
        phys_finish(a, op);
    endtask

    initial begin
        rst = 1'b0; load_req = 1'b0; level = 3'd0; r_req = 1'b0; r_addr = 6'd0;
        p_req = 1'b0; p_addr = 6'd0; p_op = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        tick();
        rst = 1'b1;

        // Automatic level-0 load after reset release
        wait_load();
        set_model(0);
        check_eq("lvl0_count", brick_count, 8);
        check_eq("lvl0_cleared", cleared, 0);
        for (int a = 0; a <= 8; a++) render_read(6'(a));

        // Plain physics read with idle render
        phys_start(6'd2, 1'b0);
        @(negedge clk);
        check_eq("rd_gnt", p_gnt, 1);
        tick();
        @(negedge clk);
        check_eq("rd_done", p_done, 1);
        p_req = 1'b0;
        tick();

        // Hit on a hardness-1 brick, then a hit on the now-empty slot
        phys_op(6'd0, 1'b1);
        render_read(6'd0);
        phys_op(6'd0, 1'b1);
        check_eq("empty_hit_count", brick_count, 7);

        // Physics against continuous render traffic
        r_req  = 1'b1;
        r_addr = 6'd5;
`ifdef BRICK_ARB_STARVE_EN
        phys_start(6'd1, 1'b1);
        for (int c = 1; c <= 19; c++) begin
            if (c != 9 && c != 18) rq.push_back(model[5]);
            @(negedge clk);
            check_eq("starve_gnt", p_gnt, c == 9);
            check_eq("starve_done", p_done, c == 19);
            if (c == 19) p_req = 1'b0;
            tick();
        end
        r_req = 1'b0;
        model[1] = model[1] - 2'd1;
        check_eq("starve_count", brick_count, model_count());
`else
        phys_start(6'd1, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            rq.push_back(model[5]);
            @(negedge clk);
            check_eq("no_starve_gnt", p_gnt, 0);
            tick();
        end
        r_req = 1'b0;
        phys_finish(6'd1, 1'b1);
`endif

        // Load request while a hit is pending its write
        phys_start(6'd2, 1'b1);
        @(negedge clk);
        check_eq("pend_gnt", p_gnt, 1);
        tick();
        load_req = 1'b1;
        level    = 3'd2;
        tick();
        load_req = 1'b0;
        @(negedge clk);
        check_eq("pend_done", p_done, 1);
        check_eq("pend_not_busy", load_busy, 0);
        p_req = 1'b0;
        wait_load();
        set_model(2);
        check_eq("lvl2_count", brick_count, 24);
        check_eq("lvl2_cleared", cleared, 0);
        render_read(6'd0);
        render_read(6'd16);
        render_read(6'd23);
        render_read(6'd24);

        // Reload level 0 and knock every brick out
        load_req = 1'b1;
        level    = 3'd0;
        tick();
        load_req = 1'b0;
        wait_load();
        set_model(0);
        for (int a = 0; a < 8; a++) begin
            while (model[a] != 2'd0) phys_op(6'(a), 1'b1);
        end
        check_eq("all_cleared", cleared, 1);

        // Reset in the middle of a load
        load_req = 1'b1;
        level    = 3'd3;
        tick();
        load_req = 1'b0;
        repeat (10) tick();
        rst = 1'b0;
        #1;
        check_all_zero("midload_rst");
        tick();
        tick();
        rst = 1'b1;
        wait_load();
        set_model(0);
        render_read(6'd8);
        render_read(6'd0);
        check_eq("reload_count", brick_count, 8);
        tick();
        tick();
        check_eq("rq_left", rq.size(), 0);
        check_eq("pq_left", pq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
